// File: rtl/flow_driver.sv
// Operand sequencer and result collector for a 4-operand, fixed-latency datapath.
// Optional define FLOW_DRV_STALL_EN adds a stall input that skips issue slots.
module flow_driver #(
  parameter int W     = 32,
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [W-1:0]     seed,
`ifdef FLOW_DRV_STALL_EN
  input  logic             stall,
`endif
  output logic [W-1:0]     A1,
  output logic [W-1:0]     B1,
  output logic [W-1:0]     A2,
  output logic [W-1:0]     B2,
  output logic             op_valid,
  input  logic [W-1:0]     C,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] res_cnt,
  output logic [W-1:0]     checksum
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     seed_q, seed_d;
  logic [CNT_W-1:0] issue_idx;
  logic [W-1:0]     op_base;
  logic             op_valid_q, op_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     a1_q, b1_q, a2_q, b2_q;
  logic [W-1:0]     a1_d, b1_d, a2_d, b2_d;
  logic [LAT-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0] res_cnt_q;
  logic [W-1:0]     checksum_q;
  logic             clear;
  logic             stall_w;

`ifdef FLOW_DRV_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // Next shift-register contents; DRAIN may finish once nothing remains in flight after this edge.
  assign sr_d = (sr_q << 1) | LAT'(op_valid_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    seed_d     = seed_q;
    issue_idx  = idx_q;
    op_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    clear      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d     = count;
          seed_d    = seed;
          clear     = 1'b1;
          issue_idx = '0;
          if (count != '0) begin
            state_d    = ISSUE;
            op_valid_d = 1'b1;
            idx_d      = CNT_W'(1);
            busy_d     = 1'b1;
          end else begin
            state_d = DONE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        busy_d = 1'b1;
        if (idx_q == cnt_q) begin
          state_d = DRAIN;
        end else if (!stall_w) begin
          op_valid_d = 1'b1;
          idx_d      = idx_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (sr_d == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_base = seed_d + (W'(issue_idx) << 2);
  assign a1_d    = op_valid_d ? op_base            : '0;
  assign b1_d    = op_valid_d ? op_base + W'(1)    : '0;
  assign a2_d    = op_valid_d ? op_base + W'(2)    : '0;
  assign b2_d    = op_valid_d ? op_base + W'(3)    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      seed_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      a1_q       <= '0;
      b1_q       <= '0;
      a2_q       <= '0;
      b2_q       <= '0;
      sr_q       <= '0;
      res_cnt_q  <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seed_q     <= seed_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      a2_q       <= a2_d;
      b2_q       <= b2_d;
      sr_q       <= sr_d;
      if (clear) begin
        checksum_q <= '0;
        res_cnt_q  <= '0;
      end else if (sr_q[LAT-1]) begin
        checksum_q <= checksum_q + C;
        res_cnt_q  <= res_cnt_q + CNT_W'(1);
      end
    end
  end

  assign A1       = a1_q;
  assign B1       = b1_q;
  assign A2       = a2_q;
  assign B2       = b2_q;
  assign op_valid = op_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign res_cnt  = res_cnt_q;
  assign checksum = checksum_q;

endmodule
